// File: rtl/alu_seq.sv
// Registered, handshaked ALU: single-cycle ops complete in one step, MUL runs
// an iterative shift-add over WIDTH BUSY cycles. One operation in flight.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_SLT  = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_SLTU = 3'b110;
  localparam logic [2:0] OP_MUL  = 3'b111;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e state_q, state_d;

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;

  logic               accept;
  logic               last_iter;
  logic [2*WIDTH-1:0] acc_step;

  assign accept    = in_valid & in_ready;
  assign last_iter = (cnt_q == CNT_W'(1));
  assign acc_step  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  // Single-cycle datapath, evaluated on the live inputs at the accept edge.
  logic [WIDTH:0]   sum_ext, diff_ext;
  logic             add_v, sub_v;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;

  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign diff_ext = {1'b0, a} - {1'b0, b};
  assign add_v    = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
  assign sub_v    = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ext[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (opcode)
      OP_ADD:  begin alu_res = sum_ext[WIDTH-1:0];  alu_c = sum_ext[WIDTH];  alu_v = add_v; end
      OP_SUB:  begin alu_res = diff_ext[WIDTH-1:0]; alu_c = diff_ext[WIDTH]; alu_v = sub_v; end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      // Sign of the difference corrected by overflow gives the true signed order.
      OP_SLT:  alu_res = WIDTH'(diff_ext[WIDTH-1] ^ sub_v);
      OP_XOR:  alu_res = a ^ b;
      OP_SLTU: alu_res = WIDTH'(diff_ext[WIDTH]);
      default: alu_res = '0;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (opcode == OP_MUL) ? BUSY : DONE;
      BUSY:    if (last_iter) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Datapath next state
  logic             load;
  logic [WIDTH-1:0] new_res;
  logic             new_c, new_v;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    z_d      = z_q;
    n_d      = n_q;
    c_d      = c_q;
    v_d      = v_q;
    load     = 1'b0;
    new_res  = '0;
    new_c    = 1'b0;
    new_v    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (opcode == OP_MUL) begin
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = CNT_W'(WIDTH);
          end else begin
            load    = 1'b1;
            new_res = alu_res;
            new_c   = alu_c;
            new_v   = alu_v;
          end
        end
      end
      BUSY: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CNT_W'(1);
        if (last_iter) begin
          load    = 1'b1;
          new_res = acc_step[WIDTH-1:0];
          new_v   = |acc_step[2*WIDTH-1:WIDTH];
        end
      end
      default: ;
    endcase
    if (load) begin
      res_d = new_res;
      z_d   = ~|new_res;
      n_d   = new_res[WIDTH-1];
      c_d   = new_c;
      v_d   = new_v;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      z_q      <= z_d;
      n_q      <= n_d;
      c_q      <= c_d;
      v_q      <= v_d;
    end
  end

  assign result = res_q;
  assign flag_z = z_q;
  assign flag_n = n_q;
  assign flag_c = c_q;
  assign flag_v = v_q;

endmodule
